fgp_tx_sched: RTL and testbench

FGP_TX_SCHED -- requirements
Module: fgp_tx_sched

---
 rtl/fgp_tx_sched_if.sv | 24 ++
 rtl/fgp_tx_sched.sv | 133 +++++++++++++
 tb/tb_fgp_tx_sched.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fgp_tx_sched_if.sv
// Handshake bundle between the frame scheduler and the FGP packet transmitter.
// The scheduler takes the slave side; the frame source/transmitter side is master.
interface fgp_tx_sched_if;
   logic        frame_req;
   logic        abort;
   logic        tx_busy;
   logic        pkt_done;
   logic        pkt_start;
   logic [7:0]  pkt_offset;
   logic [16:0] rd_base;
   logic        frame_busy;
   logic        frame_done;
   logic        timeout_err;

   modport master (
      output frame_req, abort, tx_busy, pkt_done,
      input  pkt_start, pkt_offset, rd_base, frame_busy, frame_done, timeout_err
   );

   modport slave (
      input  frame_req, abort, tx_busy, pkt_done,
      output pkt_start, pkt_offset, rd_base, frame_busy, frame_done, timeout_err
   );
endinterface

// File: rtl/fgp_tx_sched.sv
// Sequences the packets of one FGP frame: start, watchdog, inter-packet gap, one-deep frame queue.
// pkt_start two cycles after frame_req when tx_busy is low; starts are withheld while tx_busy is high.
module fgp_tx_sched #(
   parameter int NUM_PACKETS    = 150,
   parameter int GAP_CYCLES     = 64,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic            clk,
   input logic            rst,
   fgp_tx_sched_if.slave  io_fgp
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_READY,
      S_START,
      S_SEND,
      S_GAP
   } state_t;

   localparam logic [7:0]  LP_LAST_OFF = 8'(NUM_PACKETS - 1);
   localparam logic [15:0] LP_GAP_LAST = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] LP_WD_LAST  = 16'(TIMEOUT_CYCLES - 1);

   state_t      r_state,   w_state_nxt;
   logic [7:0]  r_offset,  w_offset_nxt;
   logic        r_pending, w_pending_nxt;
   logic [15:0] r_wd,      w_wd_nxt;
   logic [15:0] r_gap,     w_gap_nxt;
   logic        w_frame_done;
   logic        w_timeout_err;
   logic [7:0]  w_offset_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_offset  <= 8'd0;
         r_pending <= 1'b0;
         r_wd      <= 16'd0;
         r_gap     <= 16'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_offset  <= w_offset_nxt;
         r_pending <= w_pending_nxt;
         r_wd      <= w_wd_nxt;
         r_gap     <= w_gap_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_offset_nxt  = r_offset;
      w_pending_nxt = r_pending;
      w_wd_nxt      = r_wd;
      w_gap_nxt     = r_gap;
      w_frame_done  = 1'b0;
      w_timeout_err = 1'b0;

      if (io_fgp.frame_req && (r_state != S_IDLE)) begin
         w_pending_nxt = 1'b1;
      end

      case (r_state)
         S_IDLE: begin
            if (io_fgp.frame_req || r_pending) begin
               w_state_nxt   = S_WAIT_READY;
               w_offset_nxt  = 8'd0;
               w_pending_nxt = 1'b0;
            end
         end
         S_WAIT_READY: begin
            if (!io_fgp.tx_busy) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            w_wd_nxt    = 16'd0;
            w_state_nxt = S_SEND;
         end
         S_SEND: begin
            w_wd_nxt = r_wd + 16'd1;
            if (io_fgp.pkt_done) begin
               w_gap_nxt = 16'd0;
               if (r_offset != LP_LAST_OFF) begin
                  w_offset_nxt = r_offset + 8'd1;
                  w_state_nxt  = S_GAP;
               end else begin
                  w_frame_done = 1'b1;
                  w_offset_nxt = 8'd0;
                  // A request arriving with the final pkt_done is consumed here, not queued.
                  if (r_pending || io_fgp.frame_req) begin
                     w_pending_nxt = 1'b0;
                     w_state_nxt   = S_GAP;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end
            end else if (r_wd == LP_WD_LAST) begin
               w_timeout_err = 1'b1;
               w_pending_nxt = 1'b0;
               w_offset_nxt  = 8'd0;
               w_state_nxt   = S_IDLE;
            end
         end
         S_GAP: begin
            if (r_gap == LP_GAP_LAST) begin
               w_state_nxt = S_WAIT_READY;
            end else begin
               w_gap_nxt = r_gap + 16'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (io_fgp.abort) begin
         w_state_nxt   = S_IDLE;
         w_pending_nxt = 1'b0;
         w_offset_nxt  = 8'd0;
         w_frame_done  = 1'b0;
         w_timeout_err = 1'b0;
      end
   end

   // Outputs are forced low while rst is high, before the state register has cleared.
   assign w_offset_out       = rst ? 8'd0 : r_offset;
   assign io_fgp.pkt_offset  = w_offset_out;
   assign io_fgp.rd_base     = {w_offset_out, 9'b0};
   assign io_fgp.pkt_start   = !rst && (r_state == S_START);
   assign io_fgp.frame_busy  = !rst && (r_state != S_IDLE);
   assign io_fgp.frame_done  = !rst && w_frame_done;
   assign io_fgp.timeout_err = !rst && w_timeout_err;
endmodule

// File: tb/tb_fgp_tx_sched.sv
// Directed bench for fgp_tx_sched: cycle table plus queued-frame, reset and watchdog sequences.
module tb_fgp_tx_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fgp_tx_sched_if bus_a ();
   fgp_tx_sched_if bus_b ();

   fgp_tx_sched #(.NUM_PACKETS(3), .GAP_CYCLES(4), .TIMEOUT_CYCLES(64)) u_dut_a (
      .clk(clk), .rst(rst), .io_fgp(bus_a)
   );
   fgp_tx_sched #(.NUM_PACKETS(3), .GAP_CYCLES(4), .TIMEOUT_CYCLES(8)) u_dut_b (
      .clk(clk), .rst(rst), .io_fgp(bus_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int         n;
      logic       rst, req, abt, txb, done;
      logic       st, bsy, fd, te;
      logic [7:0] off;
   } vec_t;
   vec_t vq[$];

   logic [7:0] starts[$];
   int         n_fd = 0;

   function automatic void add(int n, logic rs, logic rq, logic ab, logic tb, logic dn,
                               logic st, logic bsy, logic fd, logic te, logic [7:0] off);
      vec_t v;
      v.n = n; v.rst = rs; v.req = rq; v.abt = ab; v.txb = tb; v.done = dn;
      v.st = st; v.bsy = bsy; v.fd = fd; v.te = te; v.off = off;
      vq.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs_a();
      return 32'({bus_a.pkt_start, bus_a.frame_busy, bus_a.frame_done, bus_a.timeout_err,
                  bus_a.pkt_offset, bus_a.rd_base});
   endfunction

   task automatic drive(input logic rq, input logic ab, input logic tb, input logic dn);
      @(negedge clk);
      rst = 1'b0;
      bus_a.frame_req = rq; bus_a.abort = ab; bus_a.tx_busy = tb; bus_a.pkt_done = dn;
   endtask

   task automatic wait_start(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         drive(0, 0, 0, 0);
         #2;
         if (bus_a.pkt_start) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Packet lasts three cycles from pkt_start; optional frame_req mid-packet and with pkt_done.
   task automatic do_packet(input logic req_mid, input logic req_done, output logic fd);
      logic ok;
      wait_start(ok);
      chk("start_seen", 32'(ok), 32'd1);
      drive(req_mid, 0, 0, 0);
      drive(0, 0, 0, 0);
      drive(req_done, 0, 0, 1);
      #2;
      fd = bus_a.frame_done;
   endtask

   task automatic chk_two_frames(input string tag);
      logic [7:0] exp_off [6];
      exp_off = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
      chk({tag, "_nstarts"}, 32'(starts.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("%s_off%0d", tag, i),
             32'((i < starts.size()) ? starts[i] : 8'hFF), 32'(exp_off[i]));
      end
      chk({tag, "_nfd"}, 32'(n_fd), 32'd2);
   endtask

   always @(negedge clk) begin
      #2;
      if (bus_a.pkt_start) starts.push_back(bus_a.pkt_offset);
      if (bus_a.frame_done) n_fd++;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      logic fd;
      logic ok;
      int   k_to;
      logic saw_fd;

      bus_a.frame_req = 0; bus_a.abort = 0; bus_a.tx_busy = 0; bus_a.pkt_done = 0;
      bus_b.frame_req = 0; bus_b.abort = 0; bus_b.tx_busy = 0; bus_b.pkt_done = 0;

      // n rst req abt txb done | start busy fdone terr offset
      add(1, 1,0,0,0,0, 0,0,0,0,0);
      add(1, 0,1,0,0,0, 0,0,0,0,0);
      add(1, 0,0,0,0,0, 0,1,0,0,0);
      add(1, 0,0,0,0,0, 1,1,0,0,0);
      add(9, 0,0,0,0,0, 0,1,0,0,0);
      add(1, 0,0,0,0,1, 0,1,0,0,0);
      add(4, 0,0,0,0,0, 0,1,0,0,1);
      add(1, 0,0,0,0,0, 0,1,0,0,1);
      add(1, 0,0,0,0,0, 1,1,0,0,1);
      add(9, 0,0,0,0,0, 0,1,0,0,1);
      add(1, 0,0,0,0,1, 0,1,0,0,1);
      add(4, 0,0,0,0,0, 0,1,0,0,2);
      add(1, 0,0,0,0,0, 0,1,0,0,2);
      add(1, 0,0,0,0,0, 1,1,0,0,2);
      add(9, 0,0,0,0,0, 0,1,0,0,2);
      add(1, 0,0,0,0,1, 0,1,1,0,2);
      add(3, 0,0,0,0,0, 0,0,0,0,0);
      add(1, 0,0,0,0,1, 0,0,0,0,0);
      add(2, 0,0,0,0,0, 0,0,0,0,0);
      add(1, 0,1,0,0,0, 0,0,0,0,0);
      add(20,0,0,0,1,0, 0,1,0,0,0);
      add(1, 0,0,0,0,0, 0,1,0,0,0);
      add(1, 0,0,0,0,0, 1,1,0,0,0);
      add(1, 0,0,1,0,0, 0,1,0,0,0);
      add(2, 0,0,0,0,0, 0,0,0,0,0);
      add(1, 0,1,0,0,0, 0,0,0,0,0);
      add(1, 0,0,0,0,0, 0,1,0,0,0);
      add(1, 0,0,0,0,0, 1,1,0,0,0);
      add(2, 0,0,0,0,0, 0,1,0,0,0);
      add(1, 0,0,0,0,1, 0,1,0,0,0);
      add(2, 0,0,0,0,0, 0,1,0,0,1);
      add(1, 0,0,1,0,0, 0,1,0,0,1);
      add(8, 0,0,0,0,0, 0,0,0,0,0);
      add(1, 0,1,1,0,0, 0,0,0,0,0);
      add(3, 0,0,0,0,0, 0,0,0,0,0);

      foreach (vq[i]) begin
         for (int k = 0; k < vq[i].n; k++) begin
            @(negedge clk);
            rst = vq[i].rst;
            bus_a.frame_req = vq[i].req; bus_a.abort = vq[i].abt;
            bus_a.tx_busy = vq[i].txb;   bus_a.pkt_done = vq[i].done;
            #2;
            chk($sformatf("vec%0d.%0d", i, k), outs_a(),
                32'({vq[i].st, vq[i].bsy, vq[i].fd, vq[i].te, vq[i].off, vq[i].off, 9'b0}));
         end
      end

      // Two queued requests: second is held pending, third is dropped.
      starts.delete(); n_fd = 0;
      drive(1, 0, 0, 0);
      do_packet(0, 0, fd);
      do_packet(1, 0, fd);
      do_packet(1, 0, fd);
      chk("q_fd_frame1", 32'(fd), 32'd1);
      do_packet(0, 0, fd);
      do_packet(0, 0, fd);
      do_packet(0, 0, fd);
      chk("q_fd_frame2", 32'(fd), 32'd1);
      repeat (20) drive(0, 0, 0, 0);
      #2;
      chk("q_idle_busy", 32'(bus_a.frame_busy), 32'd0);
      chk_two_frames("q");

      // frame_req coinciding with the final pkt_done.
      starts.delete(); n_fd = 0;
      drive(1, 0, 0, 0);
      do_packet(0, 0, fd);
      do_packet(0, 0, fd);
      do_packet(0, 1, fd);
      chk("c_fd_frame1", 32'(fd), 32'd1);
      do_packet(0, 0, fd);
      do_packet(0, 0, fd);
      do_packet(0, 0, fd);
      chk("c_fd_frame2", 32'(fd), 32'd1);
      repeat (20) drive(0, 0, 0, 0);
      #2;
      chk("c_idle_busy", 32'(bus_a.frame_busy), 32'd0);
      chk_two_frames("c");

      // Reset during SEND of offset 1.
      starts.delete(); n_fd = 0;
      drive(1, 0, 0, 0);
      do_packet(0, 0, fd);
      wait_start(ok);
      chk("r_start1_seen", 32'(ok), 32'd1);
      chk("r_start1_off", 32'(bus_a.pkt_offset), 32'd1);
      drive(0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      bus_a.frame_req = 1'b1;
      #2;
      chk("r_outs_during_rst", outs_a(), 32'd0);
      drive(0, 0, 0, 0);
      #2;
      chk("r_outs_after_rst", outs_a(), 32'd0);
      repeat (20) drive(0, 0, 0, 0);
      chk("r_no_restart", 32'(starts.size()), 32'd2);
      drive(1, 0, 0, 0);
      wait_start(ok);
      chk("r_new_start_seen", 32'(ok), 32'd1);
      chk("r_new_start_off", 32'(bus_a.pkt_offset), 32'd0);
      drive(0, 1, 0, 0);
      repeat (2) drive(0, 0, 0, 0);

      // Watchdog on the TIMEOUT_CYCLES=8 instance.
      @(negedge clk); bus_b.frame_req = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); bus_b.frame_req = 1'b0;
         #2;
         if (bus_b.pkt_start) begin ok = 1'b1; break; end
      end
      chk("t_start_seen", 32'(ok), 32'd1);
      k_to = -1; saw_fd = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         #2;
         if (bus_b.frame_done) saw_fd = 1'b1;
         if (bus_b.timeout_err) begin k_to = k; break; end
      end
      chk("t_timeout_delay", 32'(k_to), 32'd8);
      chk("t_no_frame_done", 32'(saw_fd), 32'd0);
      @(negedge clk);
      #2;
      chk("t_busy_after", 32'({bus_b.frame_busy, bus_b.timeout_err}), 32'd0);

      // pkt_done in the last watchdog cycle wins over the timeout.
      @(negedge clk); bus_b.frame_req = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); bus_b.frame_req = 1'b0;
         #2;
         if (bus_b.pkt_start) begin ok = 1'b1; break; end
      end
      chk("p_start_seen", 32'(ok), 32'd1);
      repeat (7) @(negedge clk);
      @(negedge clk); bus_b.pkt_done = 1'b1;
      #2;
      chk("p_no_timeout", 32'({bus_b.timeout_err, bus_b.frame_done}), 32'd0);
      @(negedge clk); bus_b.pkt_done = 1'b0;
      #2;
      chk("p_in_gap", 32'({bus_b.frame_busy, bus_b.pkt_offset}), 32'({1'b1, 8'd1}));
      @(negedge clk); bus_b.abort = 1'b1;
      @(negedge clk); bus_b.abort = 1'b0;
      #2;
      chk("p_abort_idle", 32'(bus_b.frame_busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
